// File: rtl/vga_capture.sv
// vga_capture
// Receive side of the 640x480 VGA path. Recovers pixel coordinates, frame
// framing and a lock indication from hsync/vsync alone, and captures the
// active-area pixel data.
//
// Ports
//   clk          system clock (2x pixel rate)
//   rst          asynchronous, active-low reset
//   hsync_in     horizontal sync, active low
//   vsync_in     vertical sync, active low
//   rgb_in[5:0]  pixel data
//   pix_valid    one-clk strobe: pix_x/pix_y/pix_data hold an active pixel
//   pix_x[9:0]   column of the captured pixel
//   pix_y[9:0]   row of the captured pixel
//   pix_data[5:0] captured rgb
//   frame_start  one-clk pulse together with the row-0/column-0 pix_valid
//   locked       timing verified for a full frame
//   sync_err     one-clk pulse on a line- or frame-length violation
module vga_capture #(
  parameter int H_TOTAL  = 800,
  parameter int H_START  = 146,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 521,
  parameter int V_START  = 30,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [5:0] rgb_in,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [5:0] pix_data,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_SYNC = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_PIX_LO  = 10'(H_START);
  localparam logic [9:0] H_PIX_HI  = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0] V_LINES   = 10'(V_TOTAL);
  localparam logic [9:0] V_ROW_LO  = 10'(V_START);
  localparam logic [9:0] V_ROW_HI  = 10'(V_START + V_ACTIVE - 1);
  localparam logic [9:0] CNT_MAX   = 10'h3FF;

  state_e     state_q, state_d;
  logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [5:0] rgb_q;
  logic       phase_q, phase_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] lcnt_q, lcnt_d;
  logic       seen_q, seen_d;   // an hsync fall has been indexed since the last vsync fall
  logic       pix_valid_q, pix_valid_d;
  logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [5:0] pix_data_q, pix_data_d;
  logic       frame_start_q, frame_start_d;
  logic       locked_q, locked_d;
  logic       sync_err_q, sync_err_d;

  logic       hs_fall_s, vs_fall_s, pix_tick_s;
  logic       h_err_s, v_err_s, err_s, active_s;
  logic [9:0] lines_s, col_s, row_s;

  // Next-state logic: edge detection, tick phase, counters, FSM and capture.
  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    lcnt_d        = lcnt_q;
    seen_d        = seen_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_data_d    = pix_data_q;
    frame_start_d = 1'b0;

    hs_fall_s  = hs_prev_q & ~hs_q;
    vs_fall_s  = vs_prev_q & ~vs_q;
    // The hsync fall is always tick 0; ticks then alternate every other clk.
    pix_tick_s = hs_fall_s | ~phase_q;
    phase_d    = pix_tick_s;

    if (hs_fall_s) begin
      hcnt_d = 10'd0;
    end else if (pix_tick_s && (hcnt_q != CNT_MAX)) begin
      hcnt_d = hcnt_q + 10'd1;
    end else begin
      hcnt_d = hcnt_q;
    end

    // Lines seen since the previous vsync fall (lcnt holds the last index).
    lines_s = seen_q ? (lcnt_q + 10'd1) : 10'd0;

    // vsync is handled first, so a coincident hsync fall becomes index 0.
    if (vs_fall_s) begin
      lcnt_d = 10'd0;
      seen_d = hs_fall_s;
    end else if (hs_fall_s) begin
      seen_d = 1'b1;
      if (!seen_q) begin
        lcnt_d = 10'd0;
      end else if (lcnt_q != CNT_MAX) begin
        lcnt_d = lcnt_q + 10'd1;
      end else begin
        lcnt_d = lcnt_q;
      end
    end else begin
      lcnt_d = lcnt_q;
    end

    h_err_s = hs_fall_s && (state_q != S_HUNT) && (hcnt_q != H_LAST);
    v_err_s = vs_fall_s && (state_q != S_HUNT) && (lines_s != V_LINES);
    err_s   = h_err_s | v_err_s;

    case (state_q)
      S_HUNT: begin
        if (vs_fall_s) state_d = S_SYNC;
        else           state_d = S_HUNT;
      end
      S_SYNC: begin
        if (vs_fall_s) state_d = v_err_s ? S_SYNC : S_LOCK;
        else           state_d = S_SYNC;
      end
      S_LOCK: begin
        if (v_err_s) state_d = S_SYNC;
        else         state_d = S_LOCK;
      end
      default: state_d = S_HUNT;
    endcase
    // A bad line length invalidates the horizontal phase entirely.
    if (h_err_s) begin
      state_d = S_HUNT;
    end else begin
      state_d = state_d;
    end

    col_s = hcnt_d - H_PIX_LO;
    row_s = lcnt_d - V_ROW_LO;
    // hcnt_d/lcnt_d are the indices of the tick being sampled now.
    active_s = (state_q == S_LOCK) && !err_s && pix_tick_s && seen_d &&
               (hcnt_d >= H_PIX_LO) && (hcnt_d <= H_PIX_HI) &&
               (lcnt_d >= V_ROW_LO) && (lcnt_d <= V_ROW_HI);

    if (active_s) begin
      pix_valid_d   = 1'b1;
      pix_x_d       = col_s;
      pix_y_d       = row_s;
      pix_data_d    = rgb_q;
      frame_start_d = (col_s == 10'd0) && (row_s == 10'd0);
    end else begin
      pix_valid_d   = 1'b0;
    end

    locked_d   = (state_d == S_LOCK);
    sync_err_d = err_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_HUNT;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      rgb_q         <= 6'd0;
      phase_q       <= 1'b0;
      hcnt_q        <= 10'd0;
      lcnt_q        <= 10'd0;
      seen_q        <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      pix_data_q    <= 6'd0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hsync_in;
      vs_q          <= vsync_in;
      hs_prev_q     <= hs_q;
      vs_prev_q     <= vs_q;
      rgb_q         <= rgb_in;
      phase_q       <= phase_d;
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      seen_q        <= seen_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture with reduced timing so several frames fit in a
// short run. A line-level model predicts the pixel stream, error pulses and
// lock state; a monitor compares DUT strobes against the predicted queues.
module tb_vga_capture;

  localparam int H_TOTAL  = 40;
  localparam int H_START  = 8;
  localparam int H_ACTIVE = 24;
  localparam int V_TOTAL  = 12;
  localparam int V_START  = 3;
  localparam int V_ACTIVE = 6;
  localparam int HSW      = 4;    // hsync low width in ticks
  localparam int LONG_LEN = 2000;

  localparam int M_HUNT = 0;
  localparam int M_SYNC = 1;
  localparam int M_LOCK = 2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] d;
    logic       fs;
  } pix_t;

  logic       clk, rst, hsync_in, vsync_in;
  logic [5:0] rgb_in;
  logic       pix_valid, frame_start, locked, sync_err;
  logic [9:0] pix_x, pix_y;
  logic [5:0] pix_data;

  vga_capture #(
    .H_TOTAL(H_TOTAL), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_START(V_START), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rgb_in(rgb_in), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .frame_start(frame_start), .locked(locked),
    .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  pix_t pix_q[$];
  int   err_q[$];
  int   serial     = 0;
  int   cur_serial = -1;

  // Reference model state, kept at the level of whole lines and frames.
  int   mode        = M_HUNT;
  int   lines_since = 0;
  int   prev_len    = 0;
  bit   prev_vs     = 1'b1;
  logic [5:0] rgb_arr [0:LONG_LEN-1];

  task automatic monitor_loop();
    pix_t e;
    int   s;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pix_valid) begin
          n_checks++;
          if (pix_q.size() == 0) begin
            n_fail++;
            $display("FAIL pix_unexpected: got x=%0d y=%0d d=%0h, required no pixel", pix_x, pix_y, pix_data);
          end else begin
            e = pix_q.pop_front();
            if (pix_x !== e.x || pix_y !== e.y || pix_data !== e.d || frame_start !== e.fs) begin
              n_fail++;
              $display("FAIL pix: got x=%0d y=%0d d=%0h fs=%0b, required x=%0d y=%0d d=%0h fs=%0b",
                       pix_x, pix_y, pix_data, frame_start, e.x, e.y, e.d, e.fs);
            end
          end
        end
        if (sync_err) begin
          n_checks++;
          if (err_q.size() == 0) begin
            n_fail++;
            $display("FAIL sync_err_unexpected: got pulse in line %0d, required none", cur_serial);
          end else begin
            s = err_q.pop_front();
            if (s != cur_serial) begin
              n_fail++;
              $display("FAIL sync_err_line: got line %0d, required line %0d", cur_serial, s);
            end
          end
        end
      end
    end
  endtask

  // Predict one line from its start (vsync/hsync falls), then drive it.
  task automatic run_line(input int len, input bit vs_lvl, input int rst_at);
    bit   vs_fall, err;
    int   nm, row;
    pix_t e;
    for (int t = 0; t < len; t++) rgb_arr[t] = 6'($urandom);

    vs_fall = prev_vs && !vs_lvl;
    nm  = mode;
    err = 1'b0;
    if (vs_fall) begin
      if (mode == M_HUNT) nm = M_SYNC;
      else if (lines_since != V_TOTAL) begin nm = M_SYNC; err = 1'b1; end
      else nm = M_LOCK;
      lines_since = 0;
    end
    if (mode != M_HUNT && prev_len != H_TOTAL) begin
      nm  = M_HUNT;
      err = 1'b1;
    end
    if (err) err_q.push_back(serial);
    lines_since++;
    mode = nm;
    row  = lines_since - 1 - V_START;
    if (mode == M_LOCK && row >= 0 && row < V_ACTIVE) begin
      for (int c = 0; c < H_ACTIVE; c++) begin
        if (H_START + c < len) begin
          e.x  = 10'(c);
          e.y  = 10'(row);
          e.d  = rgb_arr[H_START + c];
          e.fs = (row == 0 && c == 0);
          pix_q.push_back(e);
        end
      end
    end
    prev_len   = len;
    prev_vs    = vs_lvl;
    cur_serial = serial;
    serial++;

    for (int t = 0; t < len; t++) begin
      hsync_in = (t < HSW) ? 1'b0 : 1'b1;
      vsync_in = vs_lvl;
      rgb_in   = rgb_arr[t];
      if (t == rst_at) begin
        rst = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid, pix_x, pix_y, pix_data, frame_start, locked, sync_err} !== 30'd0) begin
          n_fail++;
          $display("FAIL reset_mid_frame: got outputs %0h, required 0",
                   {pix_valid, pix_x, pix_y, pix_data, frame_start, locked, sync_err});
        end
        pix_q.delete();
        err_q.delete();
        mode        = M_HUNT;
        lines_since = 0;
      end
      if (rst_at >= 0 && t == rst_at + 1) rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (t == HSW + 2) begin
        n_checks++;
        if (locked !== (mode == M_LOCK)) begin
          n_fail++;
          $display("FAIL locked line %0d: got %0b, required %0b", cur_serial, locked, (mode == M_LOCK));
        end
      end
    end
  endtask

  task automatic run_frame(input int nlines, input bit vs_en, input int short_at,
                           input int long_at, input int rst_line);
    int len;
    for (int l = 0; l < nlines; l++) begin
      if (l == short_at)     len = H_TOTAL - 1;
      else if (l == long_at) len = LONG_LEN;
      else                   len = H_TOTAL;
      run_line(len, !(vs_en && l < 2), (l == rst_line) ? 20 : -1);
    end
  endtask

  initial begin
    rst      = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rgb_in   = 6'd0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({pix_valid, pix_x, pix_y, pix_data, frame_start, locked, sync_err} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_state: got outputs %0h, required 0",
               {pix_valid, pix_x, pix_y, pix_data, frame_start, locked, sync_err});
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // hsync only: never locks, no pixels, no errors
    repeat (2) run_frame(V_TOTAL, 1'b0, -1, -1, -1);
    // clean stream: lock at the second vsync fall, then full frames
    repeat (4) run_frame(V_TOTAL, 1'b1, -1, -1, -1);
    // one short line while locked, then relock
    run_frame(V_TOTAL, 1'b1, 5, -1, -1);
    repeat (3) run_frame(V_TOTAL, 1'b1, -1, -1, -1);
    // frame one line short: error at the vsync fall, back through SYNC
    run_frame(V_TOTAL - 1, 1'b1, -1, -1, -1);
    repeat (3) run_frame(V_TOTAL, 1'b1, -1, -1, -1);
    // missing hsync for a long stretch while locked
    run_frame(V_TOTAL, 1'b1, -1, 5, -1);
    repeat (3) run_frame(V_TOTAL, 1'b1, -1, -1, -1);
    // reset mid-frame while locked, then shift the pixel phase by one clk
    run_frame(V_TOTAL, 1'b1, -1, -1, 5);
    @(posedge clk); #1;
    repeat (3) run_frame(V_TOTAL, 1'b1, -1, -1, -1);

    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (pix_q.size() != 0) begin
      n_fail++;
      $display("FAIL pix_missing: got %0d pixels outstanding, required 0", pix_q.size());
    end
    n_checks++;
    if (err_q.size() != 0) begin
      n_fail++;
      $display("FAIL sync_err_missing: got %0d pulses outstanding, required 0", err_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
